// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access controller.
// Optional cycle counter selected by CSR_CYCLE_CNT_EN.
package csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  localparam logic [11:0] CSR_ADDR_CYCLE  = 12'hC00;
  localparam logic [11:0] CSR_ADDR_CYCLEH = 12'hC80;
  localparam logic [11:0] CSR_RO_MASK     = 12'hC00;

  function automatic logic csr_is_ro(
    input logic [11:0] a
  );
    return (a & CSR_RO_MASK) == CSR_RO_MASK;
  endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Execute-stage request/response and CSR file port bundle.
// slave = controller side, master = pipeline and CSR file side.
interface csr_access_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) ();

  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [AWIDTH-1:0] req_addr;
  logic [4:0]        req_rs1_idx;
  logic [DWIDTH-1:0] req_rs1_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_illegal;
  logic [AWIDTH-1:0] csr_addr;
  logic [DWIDTH-1:0] csr_wdata;
  logic              csr_we;
  logic [DWIDTH-1:0] csr_rdata;

  modport slave (
    input  req_valid,
    output req_ready,
    input  req_funct3,
    input  req_addr,
    input  req_rs1_idx,
    input  req_rs1_data,
    output rsp_valid,
    input  rsp_ready,
    output rsp_rdata,
    output rsp_illegal,
    output csr_addr,
    output csr_wdata,
    output csr_we,
    input  csr_rdata
  );

  modport master (
    output req_valid,
    input  req_ready,
    output req_funct3,
    output req_addr,
    output req_rs1_idx,
    output req_rs1_data,
    input  rsp_valid,
    output rsp_ready,
    input  rsp_rdata,
    input  rsp_illegal,
    input  csr_addr,
    input  csr_wdata,
    input  csr_we,
    output csr_rdata
  );

endinterface

// File: rtl/csr_alu.sv
// Zicsr read-modify-write value, write request and legality.
module csr_alu
  import csr_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input  logic [DWIDTH-1:0] old_i,
  input  logic [DWIDTH-1:0] operand_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [AWIDTH-1:0] addr_i,
  output logic [DWIDTH-1:0] new_o,
  output logic              wr_req_o,
  output logic              illegal_o
);

  logic bad_f3;
  logic set_clr;

  assign set_clr = rs1_idx_i != 5'd0;

  always_comb begin
    new_o    = old_i;
    wr_req_o = 1'b0;
    bad_f3   = 1'b0;
    unique case (1'b1)
      funct3_i == F3_RW,
      funct3_i == F3_RWI: begin
        new_o    = operand_i;
        wr_req_o = 1'b1;
      end
      funct3_i == F3_RS,
      funct3_i == F3_RSI: begin
        new_o    = old_i | operand_i;
        wr_req_o = set_clr;
      end
      funct3_i == F3_RC,
      funct3_i == F3_RCI: begin
        new_o    = old_i & ~operand_i;
        wr_req_o = set_clr;
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign illegal_o = bad_f3 |
    (wr_req_o & csr_is_ro(12'(addr_i)));

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access controller: IDLE->READ->(WRITE)->RESP.
// CSR_CYCLE_CNT_EN maps a 64-bit cycle counter at 0xC00/0xC80.
module csr_access_ctrl
  import csr_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 12
) (
  input logic         clk,
  input logic         rst,
  csr_access_ctrl_if.slave bus
);

  state_e state_q, state_d;

  logic [2:0]        f3_q;
  logic [AWIDTH-1:0] addr_q;
  logic [4:0]        idx_q;
  logic [DWIDTH-1:0] opnd_q;
  logic [DWIDTH-1:0] old_q;
  logic [DWIDTH-1:0] new_q;
  logic              ill_q;

  logic [DWIDTH-1:0] old_rd;
  logic [DWIDTH-1:0] alu_new;
  logic              alu_wr;
  logic              alu_ill;
  logic              accept;

  assign accept = (state_q == IDLE) & bus.req_valid;

`ifdef CSR_CYCLE_CNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + 64'd1;
  end

  always_comb begin
    old_rd = bus.csr_rdata;
    if (12'(addr_q) == CSR_ADDR_CYCLE)
      old_rd = DWIDTH'(cnt_q[31:0]);
    else if (12'(addr_q) == CSR_ADDR_CYCLEH)
      old_rd = DWIDTH'(cnt_q[63:32]);
  end
`else
  assign old_rd = bus.csr_rdata;
`endif

  csr_alu #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_alu (
    .old_i     (old_rd),
    .operand_i (opnd_q),
    .funct3_i  (f3_q),
    .rs1_idx_i (idx_q),
    .addr_i    (addr_q),
    .new_o     (alu_new),
    .wr_req_o  (alu_wr),
    .illegal_o (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.req_valid) state_d = READ;
      READ:  state_d = (alu_wr & ~alu_ill) ?
                       WRITE : RESP;
      WRITE: state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q   <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      opnd_q <= '0;
      old_q  <= '0;
      new_q  <= '0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        f3_q   <= bus.req_funct3;
        addr_q <= bus.req_addr;
        idx_q  <= bus.req_rs1_idx;
        opnd_q <= bus.req_funct3[2] ?
                  DWIDTH'(bus.req_rs1_idx) :
                  bus.req_rs1_data;
      end
      if (state_q == READ) begin
        old_q <= alu_ill ? '0 : old_rd;
        new_q <= alu_new;
        ill_q <= alu_ill;
      end
    end
  end

  // strobe is gated by rst so an aborting reset never writes
  assign bus.csr_we      = (state_q == WRITE) & ~rst;
  assign bus.req_ready   = state_q == IDLE;
  assign bus.rsp_valid   = state_q == RESP;
  assign bus.rsp_rdata   = old_q;
  assign bus.rsp_illegal = ill_q;
  assign bus.csr_addr    = addr_q;
  assign bus.csr_wdata   = new_q;

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
Initiator side of the CSR register file.
- Accepts one decoded Zicsr instruction per handshake from the execute stage.
- Reads the CSR, computes the read-modify-write value and drives the write strobe.
- Returns the old CSR value for rd.
- Sits between the pipeline's execute stage and the async-read/sync-write CSR register file.

Parameters:
DWIDTH, 32, CSR data width
AWIDTH, 12, CSR address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  CSR op offered
req_ready  out  1  controller can accept op
req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_addr  in  AWIDTH  CSR address
req_rs1_idx  in  5  rs1 index, or zimm for immediate forms
req_rs1_data  in  DWIDTH  rs1 register value
rsp_valid  out  1  result available
rsp_ready  in  1  pipeline consumes result
rsp_rdata  out  DWIDTH  old CSR value for rd
rsp_illegal  out  1  op illegal; rd must not be written
csr_addr  out  AWIDTH  address to CSR file
csr_wdata  out  DWIDTH  write data to CSR file
csr_we  out  1  write strobe to CSR file
csr_rdata  in  DWIDTH  combinational read data from CSR file

Behaviour:
- Reset: state=IDLE; req_ready=1; rsp_valid=0; csr_we=0; csr_addr=0; csr_wdata=0; rsp_rdata=0; rsp_illegal=0.
- A reset asserted in any state aborts the op. No write is issued in the reset cycle.
- States:
  - IDLE: req_ready=1. On req_valid, latch funct3, addr and rs1_idx. Latch the operand:
    - immediate forms (funct3[2]=1): operand = zero-extended rs1_idx
    - register forms: operand = rs1_data
    - next state READ.
  - READ: req_ready=0; csr_addr=latched addr. Sample csr_rdata into old_q. Compute:
    - RW: new = operand
    - RS: new = old | operand
    - RC: new = old & ~operand
  - Write-enable rule (wr_req):
    - RW/RWI: wr_req=1 always.
    - RS/RC/RSI/RCI: wr_req=1 only if rs1_idx != 0.
  - Legality: funct3 000 or 100, or wr_req with addr[11:10]==2'b11 (read-only space), sets illegal.
  - From READ: next state WRITE if wr_req && !illegal, else RESP.
  - WRITE: csr_we=1 for exactly one cycle with csr_addr and csr_wdata=new. Next state RESP.
  - RESP: rsp_valid=1; rsp_rdata=old_q (0 when illegal); rsp_illegal as computed. Held stable until rsp_ready. Then IDLE.
- Latency from accept to rsp_valid:
  - 3 cycles with write
  - 2 cycles without write
- No back-to-back acceptance: the next request is accepted in the cycle after the response is consumed.
- csr_we is never asserted outside WRITE. csr_wdata is don't-care when csr_we=0 but driven to the registered value.
- csr_addr holds the latched address from READ through RESP.

Optional Feature:
CSR_CYCLE_CNT_EN
- With the macro defined:
  - internal 64-bit cycle counter, reset to 0, increments every cycle.
  - Reads of 0xC00 return the low 32 bits; reads of 0xC80 return the high 32 bits. csr_rdata is ignored for those addresses.
  - Low-half carry into the high half occurs on the same edge.
- Without the macro: no counter; 0xC00/0xC80 read from the CSR file like any other address. The write-protect rule is unchanged.

Decomposition:
- Shared package csr_pkg holds:
  - funct3 encodings
  - FSM state enum (IDLE, READ, WRITE, RESP)
  - CSR_ADDR_CYCLE=12'hC00, CSR_ADDR_CYCLEH=12'hC80
  - read-only region mask
- One natural sub-module: csr_alu, purely combinational. Takes old, operand and funct3; produces new, wr_req and illegal.
- The counter stays inline under the macro.

Test Plan:
- CSRRW: file[0x340]=0x11111111, addr 0x340, rs1_data=0xDEADBEEF.
  -> csr_we one cycle at cycle 2 with wdata 0xDEADBEEF.
  -> rsp_valid at cycle 3 with rdata 0x11111111.
  -> a following read returns 0xDEADBEEF.
- CSRRS/CSRRC: file[0x300]=0x000000F0.
  -> RS with 0x0000000F writes 0x000000FF.
  -> then RC with 0x000000F0 writes 0x0000000F.
  -> each returns the prior value.
- CSRRS with rs1_idx=0 on 0x300:
  -> csr_we never asserted.
  -> rsp_valid at cycle 2 with the current value.
- Read-only space: CSRRWI zimm=5 to 0xC01.
  -> no write; rsp_illegal=1; rsp_rdata=0.
  -> funct3=100 also gives rsp_illegal=1.
- Backpressure and reset:
  - Hold rsp_ready=0 for 4 cycles. -> rsp_valid and rsp_rdata stable; req_ready=0.
  - Assert rst while in WRITE-pending READ. -> next cycle IDLE, no csr_we, all outputs at reset values.
- With CSR_CYCLE_CNT_EN: read 0xC00 twice, 10 cycles apart. -> difference equals accept-to-accept cycle count.
